// File: rtl/busmux_pkg.sv
// busmux_pkg: shared types and word-select codes for the cartridge address bus sender.
package busmux_pkg;

  // Per-channel request state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } chan_state_t;

  // j word select codes (any js with bit 1 set reads as zero)
  localparam logic [1:0] JS_LO = 2'b00;
  localparam logic [1:0] JS_HI = 2'b01;

  // f word select code carrying the audio-sample address
  localparam logic [1:0] FS_AS = 2'b11;

endpackage

// File: rtl/busmux_chan.sv
// busmux_chan: one address request channel (IDLE/REQ/GAP) with a frozen active
// register, a one-deep pending register and a sticky overwrite flag.
// Optional feature: BUSMUX_TIMEOUT_EN adds a per-request cycle counter that
// abandons a request after TIMEOUT cycles without ack and sets a sticky flag.
module busmux_chan
  import busmux_pkg::*;
#(
  parameter int unsigned W       = 19,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_vld,
  input  logic         i_ack,
  output logic         o_req,
  output logic [W-1:0] o_active,
  output logic         o_ovf,
  output logic         o_timeout
);

  chan_state_t  r_state;
  logic [W-1:0] r_active;
  logic [W-1:0] r_pend;
  logic         r_pend_vld;
  logic         r_req;
  logic         r_ovf;
  logic         w_expire;

`ifdef BUSMUX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  // Final REQ cycle of the allowed window; an ack in this same cycle still wins
  assign w_expire = (r_state == REQ) && (r_cnt == LAST);

  // Count REQ cycles; held at zero outside REQ so every request starts fresh
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == REQ) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_expire && !i_ack) r_timeout <= 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_expire = 1'b0;

  // TIMEOUT has no effect in this build
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign o_timeout        = 1'b0;
`endif

  // Request state machine: capture, hold during REQ, one-cycle low gap after ack
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_active   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_vld) begin
            r_active <= i_data;
            r_req    <= 1'b1;
            r_state  <= REQ;
          end
        end
        REQ: begin
          // Active stays frozen; new addresses land in pending, overwriting if full
          if (i_vld) begin
            r_pend     <= i_data;
            r_pend_vld <= 1'b1;
            if (r_pend_vld) r_ovf <= 1'b1;
          end
          if (i_ack || w_expire) begin
            r_req   <= 1'b0;
            r_state <= GAP;
          end
        end
        GAP: begin
          // A strobe arriving in the gap is newer than pending, so it takes priority
          r_pend_vld <= 1'b0;
          if (i_vld) begin
            r_active <= i_data;
            r_req    <= 1'b1;
            r_state  <= REQ;
          end else if (r_pend_vld) begin
            r_active <= r_pend;
            r_req    <= 1'b1;
            r_state  <= REQ;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_req    = r_req;
  assign o_active = r_active;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/busmux_tx.sv
// busmux_tx: console-side sender of the cartridge address bus. Two request
// channels (68k, audio sample) feed the j/f word muxes driven by the CPLD selects.
// Optional feature: BUSMUX_TIMEOUT_EN (request timeout, see busmux_chan).
module busmux_tx
  import busmux_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] a68k_in,
  input  logic        a68k_vld,
  input  logic [16:0] as_in,
  input  logic        as_vld,
  input  logic [1:0]  js,
  output logic [15:0] j,
  input  logic [1:0]  fs,
  output logic [15:0] f,
  output logic        a68kreq,
  input  logic        a68kack,
  output logic        asreq,
  input  logic        asack,
  output logic        a68k_ovf,
  output logic        as_ovf,
  output logic        timeout
);

  logic [18:0] w_a68k_active;
  logic [16:0] w_as_active;
  logic        w_a68k_to;
  logic        w_as_to;

  busmux_chan #(
    .W       (19),
    .TIMEOUT (TIMEOUT)
  ) u_a68k (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (a68k_in),
    .i_vld     (a68k_vld),
    .i_ack     (a68kack),
    .o_req     (a68kreq),
    .o_active  (w_a68k_active),
    .o_ovf     (a68k_ovf),
    .o_timeout (w_a68k_to)
  );

  busmux_chan #(
    .W       (17),
    .TIMEOUT (TIMEOUT)
  ) u_as (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (as_in),
    .i_vld     (as_vld),
    .i_ack     (asack),
    .o_req     (asreq),
    .o_active  (w_as_active),
    .o_ovf     (as_ovf),
    .o_timeout (w_as_to)
  );

  // j word: low or high part of the active 68k address, not gated by request
  always_comb begin
    j = '0;
    case (js)
      JS_LO:   j = w_a68k_active[15:0];
      JS_HI:   j = {13'd0, w_a68k_active[18:16]};
      default: j = '0;
    endcase
  end

  // f word: audio address with bit 3 dropped (always 0, rebuilt by the receiver)
  always_comb begin
    f = '0;
    if (fs == FS_AS) f = {w_as_active[4], w_as_active[2:0], w_as_active[16:5]};
  end

  logic w_unused_as_bit3;
  assign w_unused_as_bit3 = w_as_active[3];

  assign timeout = w_a68k_to | w_as_to;

endmodule

// File: tb/tb_busmux_tx.sv
`timescale 1ns/1ps
module tb_busmux_tx;

`ifdef BUSMUX_TIMEOUT_EN
  localparam int unsigned TO = 6;
`else
  localparam int unsigned TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] a68k_in;
  logic        a68k_vld;
  logic [16:0] as_in;
  logic        as_vld;
  logic [1:0]  js;
  logic [15:0] j;
  logic [1:0]  fs;
  logic [15:0] f;
  logic        a68kreq;
  logic        a68kack;
  logic        asreq;
  logic        asack;
  logic        a68k_ovf;
  logic        as_ovf;
  logic        timeout;

  busmux_tx #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .a68k_in  (a68k_in),
    .a68k_vld (a68k_vld),
    .as_in    (as_in),
    .as_vld   (as_vld),
    .js       (js),
    .j        (j),
    .fs       (fs),
    .f        (f),
    .a68kreq  (a68kreq),
    .a68kack  (a68kack),
    .asreq    (asreq),
    .asack    (asack),
    .a68k_ovf (a68k_ovf),
    .as_ovf   (as_ovf),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit auto_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one address in service, one waiting slot, one quiet cycle after each service
  typedef struct {
    bit          busy;
    bit          gap;
    logic [18:0] cur;
    bit          have_wait;
    logic [18:0] waitv;
    bit          ovf;
    bit          to;
    int unsigned age;
  } chm_t;

  chm_t ma, ms;
  logic [18:0] qa[$];
  logic [18:0] qs[$];

  task automatic model_step(inout chm_t m, input bit r, input bit v, input logic [18:0] d,
                            input bit ak, output bit started);
    started = 1'b0;
    if (r) begin
      m.busy = 0; m.gap = 0; m.cur = '0; m.have_wait = 0; m.waitv = '0;
      m.ovf = 0; m.to = 0; m.age = 0;
      return;
    end
    if (m.gap) begin
      m.gap = 0;
      if (v) begin
        m.cur = d; m.have_wait = 0; m.busy = 1;
      end else if (m.have_wait) begin
        m.cur = m.waitv; m.have_wait = 0; m.busy = 1;
      end
      m.age = 0;
      started = m.busy;
    end else if (m.busy) begin
      if (v) begin
        if (m.have_wait) m.ovf = 1;
        m.waitv = d; m.have_wait = 1;
      end
      m.age++;
      if (ak) begin
        m.busy = 0; m.gap = 1;
      end
`ifdef BUSMUX_TIMEOUT_EN
      else if (m.age >= TO) begin
        m.busy = 0; m.gap = 1; m.to = 1;
      end
`endif
    end else if (v) begin
      m.cur = d; m.busy = 1; m.age = 0; started = 1;
    end
  endtask

  function automatic logic [15:0] exp_j(input logic [1:0] sel, input logic [18:0] a);
    int unsigned v;
    v = a;
    if (sel == 2'd0) return 16'(v % 65536);
    if (sel == 2'd1) return 16'(v / 65536);
    return 16'd0;
  endfunction

  function automatic logic [15:0] exp_f(input logic [1:0] sel, input logic [18:0] a);
    int unsigned v;
    int unsigned r;
    v = a;
    if (sel != 2'd3) return 16'd0;
    r = ((v / 32) % 4096) + ((v % 8) * 4096) + (((v / 16) % 2) * 32768);
    return 16'(r);
  endfunction

  // Model advances on every clock edge from the inputs the DUT also samples
  initial begin
    bit sa, ss;
    forever begin
      @(posedge clk);
      model_step(ma, rst, a68k_vld, a68k_in, a68kack, sa);
      if (sa) qa.push_back(ma.cur);
      model_step(ms, rst, as_vld, {2'b00, as_in}, asack, ss);
      if (ss) qs.push_back(ms.cur);
    end
  end

  // Cycle checker: request lines, bus words and sticky flags against the model
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (chk_on) begin
        chk("a68kreq", a68kreq, ma.busy);
        chk("asreq", asreq, ms.busy);
        chk("j_word", j, exp_j(js, ma.cur));
        chk("f_word", f, exp_f(fs, ms.cur));
        chk("a68k_ovf", a68k_ovf, ma.ovf);
        chk("as_ovf", as_ovf, ms.ovf);
        chk("timeout", timeout, ma.to | ms.to);
      end
    end
  end

  // Scoreboard monitor + CPLD responder, 68k channel
  initial begin
    bit prev;
    int k;
    logic [15:0] lo, hi;
    logic [18:0] got, e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!auto_on) begin
        prev = 1'b0;
      end else if (a68kreq && !prev) begin
        js = 2'b00; #1 lo = j;
        js = 2'b01; #1 hi = j;
        js = 2'($urandom);
        got = {hi[2:0], lo};
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a68k_sb: request with address %0h but none expected", got);
        end else begin
          e = qa.pop_front();
          chk("a68k_addr", got, e);
        end
        k = $urandom_range(0, 7);
        while (k > 0 && a68kreq) begin
          @(negedge clk);
          k--;
        end
        if (a68kreq) begin
          a68kack = 1'b1;
          @(negedge clk);
          a68kack = 1'b0;
        end
        prev = a68kreq;
      end else begin
        prev = a68kreq;
        if (!a68kreq && $urandom_range(0, 15) == 0) begin
          a68kack = 1'b1;
          @(negedge clk);
          a68kack = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor + CPLD responder, audio channel
  initial begin
    bit prev;
    int k;
    logic [15:0] v;
    logic [18:0] got, e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!auto_on) begin
        prev = 1'b0;
      end else if (asreq && !prev) begin
        fs = 2'b11; #1 v = f;
        fs = 2'($urandom);
        got = {2'b00, v[11:0], v[15], 1'b0, v[14:12]};
        if (qs.size() == 0) begin
          checks++; errors++;
          $display("FAIL as_sb: request with address %0h but none expected", got);
        end else begin
          e = qs.pop_front();
          chk("as_addr", got, e);
        end
        k = $urandom_range(0, 7);
        while (k > 0 && asreq) begin
          @(negedge clk);
          k--;
        end
        if (asreq) begin
          asack = 1'b1;
          @(negedge clk);
          asack = 1'b0;
        end
        prev = asreq;
      end else begin
        prev = asreq;
        if (!asreq && $urandom_range(0, 15) == 0) begin
          asack = 1'b1;
          @(negedge clk);
          asack = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_a(input logic [18:0] a);
    a68k_in = a; a68k_vld = 1'b1;
    tick();
    a68k_vld = 1'b0;
  endtask

  task automatic send_s(input logic [16:0] a);
    as_in = a; as_vld = 1'b1;
    tick();
    as_vld = 1'b0;
  endtask

  task automatic ack_a();
    a68kack = 1'b1;
    tick();
    a68kack = 1'b0;
  endtask

  task automatic ack_s();
    asack = 1'b1;
    tick();
    asack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] tmp;
    int cnt;
    rst = 1'b1; a68k_in = '0; a68k_vld = 1'b0; as_in = '0; as_vld = 1'b0;
    js = 2'b00; fs = 2'b00; a68kack = 1'b0; asack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_a68kreq", a68kreq, 0);
    chk("rst_asreq", asreq, 0);
    chk("rst_j", j, 0);
    chk("rst_ovf", {a68k_ovf, as_ovf, timeout}, 0);

    // 68k address: latency 1, both j words, ack drops request
    tick();
    send_a(19'h5A5A5);
    js = 2'b00;
    #1 chk("t1_req", a68kreq, 1);
    chk("t1_j_lo", j, 16'hA5A5);
    js = 2'b01;
    #1 chk("t1_j_hi", j, 16'h0005);
    tick();
    js = 2'b10;
    #1 chk("t1_j_1x", j, 0);
    tick();
    ack_a();
    #1 chk("t1_req_drop", a68kreq, 0);
    tick();
    #1 chk("t1_idle", a68kreq, 0);

    // Audio address on f
    send_s(17'h1ABC7);
    fs = 2'b11;
    #1 chk("t2_req", asreq, 1);
    chk("t2_f", f, 16'h7D5E);
    fs = 2'b00;
    #1 chk("t2_f0", f, 0);
    tick();
    ack_s();
    #1 chk("t2_req_drop", asreq, 0);
    tick();

    // Overwrite of pending, frozen active, gap then resend of the newest address
    send_a(19'h33333);
    tick();
    send_a(19'h11111);
    #1 chk("t3_no_ovf", a68k_ovf, 0);
    send_a(19'h22222);
    js = 2'b00;
    #1 chk("t3_ovf", a68k_ovf, 1);
    chk("t3_frozen", j, 16'h3333);
    ack_a();
    #1 chk("t3_gap", a68kreq, 0);
    tick();
    js = 2'b00;
    #1 chk("t3_rereq", a68kreq, 1);
    chk("t3_j_lo", j, 16'h2222);
    js = 2'b01;
    #1 chk("t3_j_hi", j, 16'h0002);
    ack_a();
    tick();
    #1 chk("t3_idle", a68kreq, 0);

    // Strobe in the gap beats the pending entry, which is then dropped
    send_a(19'h44444);
    send_a(19'h55555);
    ack_a();
    send_a(19'h66666);
    js = 2'b00;
    #1 chk("t4_req", a68kreq, 1);
    chk("t4_j", j, 16'h6666);
    ack_a();
    #1 chk("t4_gap", a68kreq, 0);
    tick();
    #1 chk("t4_no_resend", a68kreq, 0);
    tick();
    #1 chk("t4_still_idle", a68kreq, 0);

    // Reset in the middle of a request with pending full
    send_a(19'h77777);
    send_a(19'h01234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    js = 2'b00;
    #1 chk("t5_req", a68kreq, 0);
    chk("t5_ovf", a68k_ovf, 0);
    chk("t5_j", j, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      #1 chk("t5_no_req", a68kreq, 0);
    end

`ifdef BUSMUX_TIMEOUT_EN
    // No ack: request abandoned after TO cycles, pending entry resent after the gap
    send_a(19'h0AAAA);
    cnt = 0;
    for (int c = 0; c < 40 && a68kreq; c++) begin
      if (c == 0) begin
        a68k_in = 19'h0BBBB; a68k_vld = 1'b1;
      end
      cnt++;
      tick();
      a68k_vld = 1'b0;
    end
    #1 chk("to_len", cnt, TO);
    chk("to_flag", timeout, 1);
    chk("to_gap", a68kreq, 0);
    tick();
    js = 2'b00;
    #1 chk("to_resend", a68kreq, 1);
    chk("to_resend_j", j, 16'hBBBB);
    ack_a();
    tick();
`else
    cnt = 0;
`endif

    // Randomized traffic with an autonomous CPLD responder
    rst = 1'b1;
    tick();
    tick();
    qa.delete();
    qs.delete();
    rst = 1'b0;
    auto_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      a68k_vld = ($urandom_range(0, 4) == 0);
      a68k_in  = 19'($urandom);
      as_vld   = ($urandom_range(0, 4) == 0);
      tmp      = 17'($urandom);
      tmp[3]   = 1'b0;
      as_in    = tmp;
      rst      = ($urandom_range(0, 799) == 0);
      tick();
    end
    a68k_vld = 1'b0;
    as_vld = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 200 && (a68kreq || asreq || qa.size() != 0 || qs.size() != 0); c++) tick();
    tick();
    chk("drain_qa", qa.size(), 0);
    chk("drain_qs", qs.size(), 0);
    chk("drain_reqs", {a68kreq, asreq}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
